pc_redirect_ctrl: RTL and testbench

Sequencer for the program counter register. It drives the counter's `pc_stall`, `br_taken` and `br_addr` inputs and arbitrates between three redirect sources: trap entry, trap return (mret) and resolved EX-stage branches/jumps. A redirect that arrives while the counter is stalled is held until the counter can accept it, so it is never lost. The block also produces the pipeline flush strobes that accompany every redirect.

---
 rtl/pc_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl : PC redirect arbiter/holder with flush and stall control
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_redirect_ctrl #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cpu_en,
  input  logic                i_imem_busy,
  input  logic                i_hazard_stall,
  input  logic                i_trap_req,
  input  logic [PC_WIDTH-1:0] i_trap_vec,
  input  logic                i_mret_req,
  input  logic [PC_WIDTH-1:0] i_mepc,
  input  logic                i_ex_br_taken,
  input  logic [PC_WIDTH-1:0] i_ex_br_addr,
  output logic                o_pc_stall,
  output logic                o_br_taken,
  output logic [PC_WIDTH-1:0] o_br_addr,
  output logic                o_flush_if_id,
  output logic                o_flush_id_ex,
  output logic                o_redirect_pending,
  output logic [31:0]         o_redirect_cnt
);

  localparam logic [1:0] c_PRIO_NONE = 2'd0;
  localparam logic [1:0] c_PRIO_BR   = 2'd1;
  localparam logic [1:0] c_PRIO_MRET = 2'd2;
  localparam logic [1:0] c_PRIO_TRAP = 2'd3;
  localparam logic [PC_WIDTH-1:0] c_ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pend_addr;
  logic [PC_WIDTH-1:0] w_pend_addr_nxt;
  logic [1:0]          r_pend_prio;
  logic [1:0]          w_pend_prio_nxt;
  logic [31:0]         r_redirect_cnt;

  logic [1:0]          w_req_prio;
  logic [PC_WIDTH-1:0] w_req_raw;
  logic [PC_WIDTH-1:0] w_req_addr;
  logic                w_req_any;
  logic                w_pend;
  logic                w_new_wins;
  logic [PC_WIDTH-1:0] w_eff_addr;
  logic                w_redir;
  logic                w_accept;

  always_comb begin
    w_req_prio = c_PRIO_NONE;
    w_req_raw  = '0;
    if (i_trap_req) begin
      w_req_prio = c_PRIO_TRAP;
      w_req_raw  = i_trap_vec;
    end else if (i_mret_req) begin
      w_req_prio = c_PRIO_MRET;
      w_req_raw  = i_mepc;
    end else if (i_ex_br_taken) begin
      w_req_prio = c_PRIO_BR;
      w_req_raw  = i_ex_br_addr;
    end
  end

  assign w_req_addr = w_req_raw & c_ALIGN_MASK;
  assign w_req_any  = i_trap_req | i_mret_req | i_ex_br_taken;
  assign w_pend     = (r_state == ST_PEND);
  // While holding, only a strictly higher-priority source may displace the entry
  assign w_new_wins = w_req_any & (~w_pend | (w_req_prio > r_pend_prio));
  assign w_eff_addr = w_new_wins ? w_req_addr : r_pend_addr;
  assign w_redir    = w_req_any | w_pend;
  assign w_accept   = w_redir & i_cpu_en & ~i_imem_busy;

  assign o_pc_stall         = i_imem_busy | (i_hazard_stall & ~w_redir);
  assign o_br_taken         = w_accept;
  assign o_br_addr          = w_redir ? w_eff_addr : '0;
  assign o_flush_if_id      = w_redir;
  assign o_flush_id_ex      = w_redir;
  assign o_redirect_pending = w_pend;
  assign o_redirect_cnt     = r_redirect_cnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_prio_nxt = r_pend_prio;
    if (w_accept) begin
      w_state_nxt     = ST_RUN;
      w_pend_addr_nxt = '0;
      w_pend_prio_nxt = c_PRIO_NONE;
    end else if (w_redir) begin
      w_state_nxt     = ST_PEND;
      w_pend_addr_nxt = w_eff_addr;
      w_pend_prio_nxt = w_new_wins ? w_req_prio : r_pend_prio;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_pend_addr    <= '0;
      r_pend_prio    <= c_PRIO_NONE;
      r_redirect_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_prio <= w_pend_prio_nxt;
      if (w_accept)
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl : scoreboard bench with directed and random redirects
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_en = 1'b0, imem_busy = 1'b0, hazard_stall = 1'b0;
  logic        trap_req = 1'b0, mret_req = 1'b0, ex_br_taken = 1'b0;
  logic [31:0] trap_vec = '0, mepc = '0, ex_br_addr = '0;
  logic        pc_stall, br_taken, flush_if_id, flush_id_ex, redirect_pending;
  logic [31:0] br_addr, redirect_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        taken;
    logic [31:0] addr;
    logic        flush;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: at most one held target, plus the accepted-redirect count
  logic        m_hold;
  logic [31:0] m_hold_addr;
  int          m_hold_prio;
  logic [31:0] m_cnt;
  logic [31:0] m_pc;

  pc_redirect_ctrl #(.PC_WIDTH(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_cpu_en           (cpu_en),
    .i_imem_busy        (imem_busy),
    .i_hazard_stall     (hazard_stall),
    .i_trap_req         (trap_req),
    .i_trap_vec         (trap_vec),
    .i_mret_req         (mret_req),
    .i_mepc             (mepc),
    .i_ex_br_taken      (ex_br_taken),
    .i_ex_br_addr       (ex_br_addr),
    .o_pc_stall         (pc_stall),
    .o_br_taken         (br_taken),
    .o_br_addr          (br_addr),
    .o_flush_if_id      (flush_if_id),
    .o_flush_id_ex      (flush_id_ex),
    .o_redirect_pending (redirect_pending),
    .o_redirect_cnt     (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check("pc_stall", {31'd0, pc_stall}, {31'd0, e.stall});
    check("br_taken", {31'd0, br_taken}, {31'd0, e.taken});
    check("br_addr", br_addr, e.addr);
    check("flush_if_id", {31'd0, flush_if_id}, {31'd0, e.flush});
    check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.flush});
    check("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
    check("redirect_cnt", redirect_cnt, e.cnt);
  endtask

  task automatic model_reset();
    m_hold = 1'b0; m_hold_addr = '0; m_hold_prio = 0; m_cnt = '0; m_pc = '0;
  endtask

  // One cycle: apply inputs after the falling edge, queue the expected response, advance the model
  task automatic drive(input logic tr, input logic [31:0] tv, input logic mr, input logic [31:0] me,
                       input logic br, input logic [31:0] ba,
                       input logic en, input logic busy, input logic haz);
    exp_t e;
    int          new_prio;
    logic [31:0] new_addr, tgt;
    logic        redir, acc;
    @(negedge clk);
    trap_req = tr; trap_vec = tv; mret_req = mr; mepc = me;
    ex_br_taken = br; ex_br_addr = ba; cpu_en = en; imem_busy = busy; hazard_stall = haz;
    new_prio = tr ? 3 : mr ? 2 : br ? 1 : 0;
    new_addr = tr ? tv : mr ? me : br ? ba : 32'd0;
    new_addr = {new_addr[31:2], 2'b00};
    redir = (new_prio != 0) || m_hold;
    tgt = (m_hold && !(new_prio > m_hold_prio)) ? m_hold_addr : new_addr;
    acc = redir && en && !busy;
    e.stall = busy || (haz && !redir);
    e.taken = acc;
    e.addr  = redir ? tgt : 32'd0;
    e.flush = redir;
    e.pend  = m_hold;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    if (acc) begin
      m_hold = 1'b0; m_hold_prio = 0; m_cnt = m_cnt + 1; m_pc = tgt;
    end else if (redir) begin
      if (!(m_hold && !(new_prio > m_hold_prio))) m_hold_prio = new_prio;
      m_hold = 1'b1; m_hold_addr = tgt;
    end
  endtask

  task automatic idle(input logic en, input logic busy);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, en, busy, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_outputs(e);
      end
    end
  end

  initial begin : stimulus
    exp_t z;
    int wait_cycles;
    model_reset();
    repeat (2) @(negedge clk);
    z = '{stall: 1'b0, taken: 1'b0, addr: 32'd0, flush: 1'b0, pend: 1'b0, cnt: 32'd0};
    compare_outputs(z);
    rst_n = 1'b1;

    // Single branch, then confirm the count on the following cycle
    drive(0, '0, 0, '0, 1, 32'h0000_0120, 1, 0, 0);
    idle(1, 0);
    check("pc_after_branch", m_pc, 32'h0000_0120);

    // Busy hold: branch in the first of three busy cycles
    drive(0, '0, 0, '0, 1, 32'h0000_0200, 1, 1, 0);
    idle(1, 1);
    idle(1, 1);
    idle(1, 0);
    idle(1, 0);

    // Trap overrides a pending branch; a later mret is dropped
    drive(0, '0, 0, '0, 1, 32'h0000_0200, 1, 1, 0);
    drive(1, 32'h8000_0004, 0, '0, 0, '0, 1, 1, 0);
    drive(0, '0, 1, 32'h0000_0300, 0, '0, 1, 1, 0);
    idle(1, 0);
    idle(1, 0);

    // Simultaneous requests
    drive(1, 32'h0000_0100, 1, 32'h0000_0200, 1, 32'h0000_0300, 1, 0, 0);
    idle(1, 0);

    // Load-use stall alone, with a redirect, and misaligned target
    drive(0, '0, 0, '0, 0, '0, 1, 0, 1);
    drive(0, '0, 0, '0, 1, 32'h0000_0040, 1, 0, 1);
    drive(0, '0, 0, '0, 1, 32'h0000_0043, 1, 0, 0);
    idle(1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 8, $urandom(), $urandom_range(0, 99) < 10, $urandom(),
            $urandom_range(0, 99) < 25, $urandom(),
            $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20);
    end

    // cpu_en low holds a pending redirect; then an asynchronous reset mid-PEND
    drive(0, '0, 0, '0, 1, 32'h0000_0abc, 1, 1, 0);
    repeat (5) idle(0, 0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #2;
    check("pending_before_reset", {31'd0, redirect_pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    compare_outputs(z);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 0);
    drive(0, '0, 0, '0, 1, 32'h0000_0010, 1, 0, 0);
    idle(1, 0);
    repeat (2) @(negedge clk);
    #5;
    check("queue_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
